// File: rtl/hsv_core_imem_arbiter.sv
// Two-requester AXI read arbiter for the instruction/data memory port.
// AR grants are locked until handshake, and R beats are routed back in acceptance order through a small order FIFO.
module hsv_core_imem_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                            clk_core,
    input  logic                            rst_core,
    input  logic [1:0]                      m_arvalid,
    output logic [1:0]                      m_arready,
    input  logic [2*ADDR_W-1:0]             m_araddr,
    input  logic [15:0]                     m_arlen,
    input  logic [5:0]                      m_arsize,
    input  logic [3:0]                      m_arburst,
    output logic [1:0]                      m_rvalid,
    input  logic [1:0]                      m_rready,
    output logic [DATA_W-1:0]               m_rdata,
    output logic [1:0]                      m_rresp,
    output logic                            m_rlast,
    output logic                            s_arvalid,
    input  logic                            s_arready,
    output logic [ADDR_W-1:0]               s_araddr,
    output logic [7:0]                      s_arlen,
    output logic [2:0]                      s_arsize,
    output logic [1:0]                      s_arburst,
    output logic                            s_arid,
    input  logic                            s_rvalid,
    output logic                            s_rready,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic [1:0]                      s_rresp,
    input  logic                            s_rlast,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic [1:0]                      ar_state
);

    // Handshakes: a transfer happens in any cycle where valid and ready are both high;
    // a raised valid keeps its payload stable until that cycle.
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_OUTSTANDING);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD0 = 2'd1;
    localparam logic [1:0] ST_HOLD1 = 2'd2;

    logic [1:0]                 state, state_nxt;
    logic                       rr;
    logic                       grant;
    logic [MAX_OUTSTANDING-1:0] order_mem;
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [PTR_W:0]             count;
    logic                       full, nonempty, head, ar_hs, r_pop;

    always_comb begin
        grant = 1'b0;
        case (state)
            ST_HOLD0: grant = 1'b0;
            ST_HOLD1: grant = 1'b1;
            default: begin
                if (m_arvalid == 2'b11) grant = rr;
                else                    grant = m_arvalid[1];
            end
        endcase
    end

    // full comes from the registered count, so a pop only reopens AR on the next cycle
    assign full      = (count == FULL_CNT);
    assign s_arvalid = ~rst_core & m_arvalid[grant] & ~full;
    assign s_araddr  = grant ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
    assign s_arlen   = grant ? m_arlen[15:8]    : m_arlen[7:0];
    assign s_arsize  = grant ? m_arsize[5:3]    : m_arsize[2:0];
    assign s_arburst = grant ? m_arburst[3:2]   : m_arburst[1:0];
    assign s_arid    = 1'b0;
    assign ar_hs     = s_arvalid & s_arready;
    assign m_arready = {ar_hs & grant, ar_hs & ~grant};

    assign nonempty  = (count != '0);
    assign head      = order_mem[rd_ptr];
    assign s_rready  = ~rst_core & nonempty & m_rready[head];
    assign m_rvalid  = {nonempty & s_rvalid & head, nonempty & s_rvalid & ~head};
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_rlast   = s_rlast;
    assign r_pop     = s_rvalid & s_rready & s_rlast;

    assign outstanding = count;
    assign ar_state    = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (s_arvalid && !s_arready) state_nxt = grant ? ST_HOLD1 : ST_HOLD0;
            end
            ST_HOLD0, ST_HOLD1: begin
                if (ar_hs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state     <= ST_IDLE;
            rr        <= 1'b0;
            order_mem <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= state_nxt;
            if (ar_hs) begin
                rr                <= ~grant;
                order_mem[wr_ptr] <= grant;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (r_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({ar_hs, r_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
